// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: constants shared by the bit-serial subtractor.
//   DEFAULT_WIDTH     default operand/result width
//   ST_IDLE/ST_SUB/ST_DONE  controller state encoding
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_full_sub.sv
// full_sub: 1-bit full subtractor, computes a - b - c.
//   a  minuend bit        b  subtrahend bit     c  borrow in
//   x  difference bit     y  borrow out
module full_sub (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x,
    output logic y
);

    assign x = a ^ b ^ c;
    // Borrow out when b exceeds a, or when they are equal and a borrow is pending.
    assign y = (~a & b) | (~(a ^ b) & c);

endmodule : full_sub

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = (a - b) mod 2^WIDTH, LSB first.
//   clk    rising-edge clock          rst_n  async active-low reset
//   start  request, sampled in IDLE   a, b   operands, captured on accept
//   busy   high while bits compute    done   one-cycle completion pulse
//   diff   result, held until next accept
//   bout   final borrow (a < b unsigned)
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Counter must hold the value WIDTH without wrapping.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_sub: WIDTH must be in 2..32");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             bit_c;
    logic             br_next_c;

    // Single shared arithmetic cell fed by the operand LSBs.
    full_sub u_full_sub (
        .a (a_q[0]),
        .b (b_q[0]),
        .c (br_q),
        .x (bit_c),
        .y (br_next_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_SUB;
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    diff_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SUB: begin
                // Result bits enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts.
                diff_d = {bit_c, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_next_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bout_d  = br_next_c;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// tb_serial_sub: checks an 8-bit and a 2-bit serial_sub against a
// cycle-level behavioural model plus directed literal expectations.
module tb_serial_sub;

    logic       clk;
    logic       rst_n;
    logic       st8, st2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       busy8, done8, bout8;
    logic       busy2, done2, bout2;
    logic [7:0] diff8;
    logic [1:0] diff2;

    int checks = 0;
    int errors = 0;
    int done_cnt [2];

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic get_busy(input int k);
        return (k == 0) ? busy8 : busy2;
    endfunction
    function automatic logic get_done(input int k);
        return (k == 0) ? done8 : done2;
    endfunction
    function automatic logic get_bout(input int k);
        return (k == 0) ? bout8 : bout2;
    endfunction
    function automatic logic [31:0] get_diff(input int k);
        return (k == 0) ? 32'(diff8) : 32'(diff2);
    endfunction

    task automatic drive(input int k, input logic s, input logic [31:0] av, input logic [31:0] bv);
        if (k == 0) begin
            st8 = s; a8 = 8'(av); b8 = 8'(bv);
        end else begin
            st2 = s; a2 = 2'(av); b2 = 2'(bv);
        end
    endtask

    // Behavioural model: an accepted request yields busy for W cycles,
    // then a one-cycle done with the arithmetic result, then one idle cycle.
    int          m_left [2];
    logic        m_busy [2];
    logic        m_done [2];
    logic        m_bout [2];
    logic        m_bor  [2];
    logic [31:0] m_diff [2];
    logic [31:0] m_res  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            logic        s;
            logic [31:0] av, bv, mask;
            int          w;
            s    = (k == 0) ? st8 : st2;
            av   = (k == 0) ? 32'(a8) : 32'(a2);
            bv   = (k == 0) ? 32'(b8) : 32'(b2);
            w    = (k == 0) ? 8 : 2;
            mask = (k == 0) ? 32'hFF : 32'h3;
            if (!rst_n) begin
                m_left[k] = 0; m_busy[k] = 0; m_done[k] = 0;
                m_bout[k] = 0; m_diff[k] = 0;
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_busy[k] = 0; m_done[k] = 1;
                    m_diff[k] = m_res[k]; m_bout[k] = m_bor[k];
                end
            end else if (m_done[k]) begin
                m_done[k] = 0;
            end else if (s) begin
                m_busy[k] = 1; m_left[k] = w; m_diff[k] = 0;
                m_res[k]  = (av - bv) & mask;
                m_bor[k]  = (av < bv);
            end
        end
    end

    // Per-cycle comparison against the model; diff is mid-shift while busy.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (get_done(k)) done_cnt[k]++;
            if (rst_n) begin
                chk((k == 0) ? "busy8" : "busy2", 32'(get_busy(k)), 32'(m_busy[k]));
                chk((k == 0) ? "done8" : "done2", 32'(get_done(k)), 32'(m_done[k]));
                if (!m_busy[k]) begin
                    chk((k == 0) ? "diff8" : "diff2", get_diff(k), m_diff[k]);
                    chk((k == 0) ? "bout8" : "bout2", 32'(get_bout(k)), 32'(m_bout[k]));
                end
            end
        end
    end

    // One operation with literal expectations; optional second start in SUB cycle 3.
    task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ed, input logic eb, input bit inject);
        int bc;
        int dc0;
        bit got;
        @(negedge clk);
        drive(k, 1'b1, av, bv);
        bc  = 0;
        got = 0;
        dc0 = done_cnt[k];
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (get_done(k)) begin
                got = 1;
                drive(k, 1'b0, 0, 0);
            end else begin
                if (get_busy(k)) bc++;
                if (inject && bc == 3) drive(k, 1'b1, 200, 1);
                else drive(k, 1'b0, $urandom, $urandom);
            end
        end
        chk("op_done_seen", 32'(got), 32'd1);
        chk("op_busy_cycles", 32'(bc), (k == 0) ? 32'd8 : 32'd2);
        chk("op_diff", get_diff(k), ed);
        chk("op_bout", 32'(get_bout(k)), 32'(eb));
        @(negedge clk);
        chk("op_idle_after", 32'(get_busy(k)), 32'd0);
        chk("op_single_done", 32'(done_cnt[k] - dc0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        int ops0;
        int cyc;
        rst_n = 1'b0;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        #1;
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_diff8", 32'(diff8), 0);
        chk("rst_bout8", 32'(bout8), 0);
        chk("rst_diff2", 32'(diff2), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 100, 37, 32'd63, 1'b0, 1'b0);
        run_op(0, 5, 9, 32'hFC, 1'b1, 1'b0);
        run_op(0, 0, 255, 32'd1, 1'b1, 1'b0);
        run_op(0, 0, 0, 32'd0, 1'b0, 1'b0);
        run_op(0, 100, 37, 32'd63, 1'b0, 1'b1);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        drive(0, 1'b1, 100, 37);
        repeat (5) @(negedge clk);
        drive(0, 1'b0, 0, 0);
        dc0 = done_cnt[0];
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_done", 32'(done8), 0);
        chk("abort_diff", 32'(diff8), 0);
        chk("abort_bout", 32'(bout8), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt[0] - dc0), 0);
        run_op(0, 255, 255, 32'd0, 1'b0, 1'b0);

        // Start held high: back-to-back random operations, checked every cycle by the model.
        ops0 = done_cnt[0];
        cyc  = 0;
        while ((done_cnt[0] - ops0) < 1000 && cyc < 20000) begin
            @(negedge clk);
            drive(0, 1'b1, $urandom, $urandom);
            cyc++;
        end
        chk("random_ops_completed", 32'(done_cnt[0] - ops0 >= 1000), 32'd1);
        drive(0, 1'b0, 0, 0);
        repeat (12) @(negedge clk);

        // Exhaustive 2-bit operand space.
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                run_op(1, 32'(ai), 32'(bi), 32'((ai - bi) & 3), (ai < bi), 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_sub

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while bits are being computed.
REQ-008 Port: done  output  1  one-cycle pulse; the result is complete.
REQ-009 Port: diff  output  WIDTH  result a-b modulo 2^WIDTH; held until the next accepted start.
REQ-010 Port: bout  output  1  final borrow; 1 when a<b unsigned.

Function
REQ-011 FSM states: IDLE, SUB, DONE.
REQ-012 Transition IDLE->SUB on a clk edge with start=1. On that edge:
- latch a and b into shift registers;
- clear the borrow register and the bit counter;
- clear diff.
REQ-013 In SUB, each edge processes one bit, LSB first, through a 1-bit full-subtractor cell:
- d = a0^b0^br;
- br_next = (~a0&b0) | (~(a0^b0)&br);
- d is shifted into the diff MSB with a right shift;
- both operand registers shift right;
- the counter increments.
REQ-014 The bit counter is $clog2(WIDTH+1) bits wide and never wraps within an operation.
REQ-015 On the WIDTH-th SUB edge: the final bit is written, bout is loaded from br_next, and the state moves to DONE.
REQ-016 Latency: done is visible after exactly WIDTH rising edges following the accepting edge.
REQ-017 Busy is high in SUB only, for exactly WIDTH cycles.
REQ-018 DONE lasts exactly one cycle, during which done=1. The state then moves to IDLE unconditionally.
REQ-019 Start is ignored in SUB and in DONE: no capture, no restart, no effect on the result.
REQ-020 Start held high continuously yields back-to-back operations with one IDLE cycle between done and the next busy.
REQ-021 Changes on a and b after the accepting edge do not affect the result.
REQ-022 Diff and bout are stable from the done cycle until the next accepting edge.

Reset
REQ-023 While rst_n=0, regardless of clk:
- state=IDLE;
- busy=0, done=0;
- diff=0, bout=0;
- operand registers, borrow and counter are all 0.
REQ-024 Reset asserted mid-operation aborts immediately. No done pulse is produced for the aborted operation.
REQ-025 After rst_n deasserts, the first accepted start begins a clean operation.

Structure
REQ-026 Shared package serial_sub_pkg holds:
- the state encoding constants (IDLE=2'd0, SUB=2'd1, DONE=2'd2);
- the default WIDTH constant.
REQ-027 The per-bit arithmetic is one combinational sub-module, full_sub, instantiated once. Ports: a, b, c in; x (difference), y (borrow) out.
REQ-028 Estimated size: 120-250 lines of RTL; no multi-cycle paths; no latches.

Verification
REQ-029 Subtraction without borrow: WIDTH=8, a=100, b=37, start pulse -> busy high 8 cycles, done once, diff=63, bout=0.
REQ-030 Subtraction with borrow: a=5, b=9 -> diff=8'hFC, bout=1. Also a=0, b=255 -> diff=1, bout=1. Also a=0, b=0 -> diff=0, bout=0.
REQ-031 Start during busy: a second start (a=200, b=1) in SUB cycle 3 is ignored -> first result is unchanged, a single done pulse, state returns to IDLE.
REQ-032 Reset mid-operation: rst_n low at SUB cycle 4 -> outputs 0 asynchronously and no done. Then start a=255, b=255 -> diff=0, bout=0.
REQ-033 Continuous start with 1000 random operand pairs -> each done matches the (a-b) mod 256 and borrow reference model, with the one-IDLE-cycle spacing holding throughout.
REQ-034 Exhaustive check at WIDTH=2 (all 16 operand pairs) -> diff and bout match the reference model, giving full-subtractor truth-table coverage.
